// File: rtl/image_stream_reader.sv
// Raster-order frame reader: walks IMG_W x IMG_H addresses from a base, absorbs the
// 1-cycle memory read latency and re-emits pixels as a valid/ready stream with sof/eol tags.
module image_stream_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic [ADDR_W-1:0] o_mem_address,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_sof,
    output logic              o_out_eol,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [ADDR_W-1:0] r_ptr;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic              r_inflight, r_if_sof, r_if_eol;

    // Two-entry FIFO; entry 0 is the head and drives the stream outputs directly.
    logic [DATA_W-1:0] r_d0, r_d1, w_d0_nxt, w_d1_nxt;
    logic              r_v0, r_v1, w_v0_nxt, w_v1_nxt;
    logic              r_sof0, r_sof1, w_sof0_nxt, w_sof1_nxt;
    logic              r_eol0, r_eol1, w_eol0_nxt, w_eol1_nxt;

    logic              w_pop, w_push, w_issue, w_accept;
    logic              w_cur_sof, w_cur_eol, w_last, w_credit_ok, w_final_hs;
    logic [1:0]        w_used;

    assign w_pop      = r_v0 & i_out_ready;
    assign w_push     = r_inflight;
    assign w_cur_eol  = (r_col == COL_LAST);
    assign w_cur_sof  = (r_col == '0) && (r_row == '0);
    assign w_last     = w_cur_eol && (r_row == ROW_LAST);
    assign w_used     = 2'(r_v0) + 2'(r_v1) + 2'(r_inflight);
    // Slots free after this cycle's pop must cover everything already owed to the FIFO.
    assign w_credit_ok = (w_used < (2'd2 + 2'(w_pop)));
    assign w_final_hs = w_pop && !r_v1 && !r_inflight;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (w_last) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_final_hs) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_ptr <= i_base_addr;
            r_col <= '0;
            r_row <= '0;
        end else if (w_issue) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            if (w_cur_eol) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Tags travel with the read so they line up with mem_data one cycle later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
            r_if_sof   <= 1'b0;
            r_if_eol   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_if_sof   <= w_issue & w_cur_sof;
            r_if_eol   <= w_issue & w_cur_eol;
        end
    end

    always_comb begin
        w_d0_nxt   = r_d0;
        w_v0_nxt   = r_v0;
        w_sof0_nxt = r_sof0;
        w_eol0_nxt = r_eol0;
        w_d1_nxt   = r_d1;
        w_v1_nxt   = r_v1;
        w_sof1_nxt = r_sof1;
        w_eol1_nxt = r_eol1;
        if (w_pop) begin
            w_d0_nxt   = r_d1;
            w_v0_nxt   = r_v1;
            w_sof0_nxt = r_sof1;
            w_eol0_nxt = r_eol1;
            w_v1_nxt   = 1'b0;
        end
        if (w_push) begin
            if (!w_v0_nxt) begin
                w_d0_nxt   = i_mem_data;
                w_v0_nxt   = 1'b1;
                w_sof0_nxt = r_if_sof;
                w_eol0_nxt = r_if_eol;
            end else begin
                w_d1_nxt   = i_mem_data;
                w_v1_nxt   = 1'b1;
                w_sof1_nxt = r_if_sof;
                w_eol1_nxt = r_if_eol;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_d0   <= '0;
            r_v0   <= 1'b0;
            r_sof0 <= 1'b0;
            r_eol0 <= 1'b0;
            r_d1   <= '0;
            r_v1   <= 1'b0;
            r_sof1 <= 1'b0;
            r_eol1 <= 1'b0;
        end else begin
            r_d0   <= w_d0_nxt;
            r_v0   <= w_v0_nxt;
            r_sof0 <= w_sof0_nxt;
            r_eol0 <= w_eol0_nxt;
            r_d1   <= w_d1_nxt;
            r_v1   <= w_v1_nxt;
            r_sof1 <= w_sof1_nxt;
            r_eol1 <= w_eol1_nxt;
        end
    end

    assign o_mem_address = r_ptr;
    assign o_out_data    = r_d0;
    assign o_out_valid   = r_v0;
    assign o_out_sof     = r_sof0;
    assign o_out_eol     = r_eol0;
    assign o_busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done        = (r_state == S_DONE);

endmodule

// File: tb/tb_image_stream_reader.sv
// Directed bench for image_stream_reader: three geometries (4x3, 4x1, 1x2) against an
// identity memory model (memory[i] = i), so every pixel value equals its read address.
module tb_image_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [15:0] base;
    logic        ready;

    logic [15:0] mad [3];
    logic [15:0] mdat [3];
    logic [15:0] odat [3];
    logic [2:0]  ov, osof, oeol, obusy, odone;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) mdat[i] <= mad[i];
    end

    image_stream_reader #(.DATA_W(16), .ADDR_W(16), .IMG_W(4), .IMG_H(3)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[0]), .i_base_addr(base),
        .o_mem_address(mad[0]), .i_mem_data(mdat[0]), .o_out_data(odat[0]),
        .o_out_valid(ov[0]), .i_out_ready(ready), .o_out_sof(osof[0]),
        .o_out_eol(oeol[0]), .o_busy(obusy[0]), .o_done(odone[0]));

    image_stream_reader #(.DATA_W(16), .ADDR_W(16), .IMG_W(4), .IMG_H(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[1]), .i_base_addr(base),
        .o_mem_address(mad[1]), .i_mem_data(mdat[1]), .o_out_data(odat[1]),
        .o_out_valid(ov[1]), .i_out_ready(ready), .o_out_sof(osof[1]),
        .o_out_eol(oeol[1]), .o_busy(obusy[1]), .o_done(odone[1]));

    image_stream_reader #(.DATA_W(16), .ADDR_W(16), .IMG_W(1), .IMG_H(2)) u_c (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[2]), .i_base_addr(base),
        .o_mem_address(mad[2]), .i_mem_data(mdat[2]), .o_out_data(odat[2]),
        .o_out_valid(ov[2]), .i_out_ready(ready), .o_out_sof(osof[2]),
        .o_out_eol(oeol[2]), .o_busy(obusy[2]), .o_done(odone[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1; mode 2: stray starts in RUN and DONE
    task automatic run_frame(input int d, input logic [15:0] b, input int w, input int h,
                             input int mode);
        int n, idx, first, lasths;
        logic stalled, hs, he;
        logic [15:0] hd;
        n = w * h; idx = 0; first = -1; lasths = -1; stalled = 1'b0;
        hd = '0; hs = 1'b0; he = 1'b0;
        base = b;
        ready = 1'b1;
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        chk("busy_after_start", obusy[d], 1);
        chk("first_addr", mad[d], b);
        for (int cyc = 0; cyc < 300 && idx < n; cyc++) begin
            ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            start_v[d] = (mode == 2) && (cyc == 4);
            if (mode == 0 && cyc < n) chk("addr_seq", mad[d], 16'(b + cyc));
            if (stalled) begin
                chk("stall_valid", ov[d], 1);
                chk("stall_data", odat[d], hd);
                chk("stall_sof", osof[d], hs);
                chk("stall_eol", oeol[d], he);
            end
            if (ov[d]) begin
                if (first < 0) first = cyc;
                if (ready) begin
                    chk("pix_data", odat[d], 16'(b + idx));
                    chk("pix_sof", osof[d], (idx == 0));
                    chk("pix_eol", oeol[d], ((idx % w) == w - 1));
                    lasths = cyc;
                    idx++;
                end
            end
            stalled = ov[d] && !ready;
            hd = odat[d]; hs = osof[d]; he = oeol[d];
            tick();
        end
        start_v[d] = 1'b0;
        chk("pixel_count", idx, n);
        if (mode == 0) begin
            chk("first_valid_cyc", first, 2);
            chk("last_hs_cyc", lasths, n + 1);
        end
        chk("done_pulse", odone[d], 1);
        chk("busy_at_done", obusy[d], 0);
        chk("valid_at_done", ov[d], 0);
        if (mode == 2) start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        chk("done_cleared", odone[d], 0);
        for (int k = 0; k < 4; k++) begin
            chk("idle_busy", obusy[d], 0);
            chk("idle_valid", ov[d], 0);
            chk("idle_done", odone[d], 0);
            tick();
        end
    endtask

    initial begin
        int hcnt;
        rst = 1'b1; start_v = '0; base = '0; ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", ov[0], 0);
        chk("rst_data", odat[0], 0);
        chk("rst_addr", mad[0], 0);
        chk("rst_sof", osof[0], 0);
        chk("rst_eol", oeol[0], 0);
        chk("rst_busy", obusy[0], 0);
        chk("rst_done", odone[0], 0);
        rst = 1'b0;
        tick();

        run_frame(0, 16'h0010, 4, 3, 0);
        run_frame(0, 16'h0010, 4, 3, 1);
        run_frame(0, 16'h0010, 4, 3, 2);
        run_frame(1, 16'hFFFE, 4, 1, 0);
        run_frame(2, 16'h0004, 1, 2, 0);

        // Reset right after the 5th pixel handshake abandons the frame.
        base = 16'h0010;
        ready = 1'b1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        hcnt = 0;
        for (int k = 0; k < 50 && hcnt < 5; k++) begin
            if (ov[0]) hcnt++;
            tick();
        end
        chk("pre_rst_hs", hcnt, 5);
        chk("pre_rst_busy", obusy[0], 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", ov[0], 0);
        chk("mid_rst_data", odat[0], 0);
        chk("mid_rst_addr", mad[0], 0);
        chk("mid_rst_busy", obusy[0], 0);
        chk("mid_rst_sof", osof[0], 0);
        chk("mid_rst_eol", oeol[0], 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_valid", ov[0], 0);
            chk("post_rst_busy", obusy[0], 0);
        end
        run_frame(0, 16'h0030, 4, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
